// File: rtl/ram512_copy_engine.sv
// Copy engine that masters the ram512 port: moves a run of words from src to dst,
// three cycles per word (address, read capture, write), then pulses done.
module ram512_copy_engine #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic [ADDR_W-1:0] src_ptr_r;
  logic [ADDR_W-1:0] dst_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   len_clamped_s;

  // Requests longer than the whole memory copy it exactly once.
  always_comb begin
    len_clamped_s = length;
    if (length > MAX_LEN) begin
      len_clamped_s = MAX_LEN;
    end else begin
      len_clamped_s = length;
    end
  end

  // Copy sequencer; every port output is set on the transition into its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      src_ptr_r <= '0;
      dst_ptr_r <= '0;
      count_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done   <= 1'b0;
          mem_we <= 1'b0;
          if (start) begin
            if (len_clamped_s != '0) begin
              src_ptr_r <= src_addr;
              dst_ptr_r <= dst_addr;
              count_r   <= len_clamped_s;
              mem_addr  <= src_addr;
              busy      <= 1'b1;
              state_r   <= RD;
            end else begin
              done    <= 1'b1;
              state_r <= DONE;
            end
          end
        end
        RD: begin
          state_r <= RDW;
        end
        RDW: begin
          // rdata is valid here for both combinational and one-cycle registered reads
          mem_wdata <= mem_rdata;
          mem_addr  <= dst_ptr_r;
          mem_we    <= 1'b1;
          state_r   <= WR;
        end
        WR: begin
          mem_we    <= 1'b0;
          src_ptr_r <= src_ptr_r + PTR_ONE;
          dst_ptr_r <= dst_ptr_r + PTR_ONE;
          count_r   <= count_r - CNT_ONE;
          if (count_r == CNT_ONE) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            mem_addr <= src_ptr_r + PTR_ONE;
            state_r  <= RD;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
